// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared state type, vector defaults and sizing helper for int_ctrl
package int_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } int_state_e;

    localparam logic [15:0] VEC_BASE_DEFAULT   = 16'h0100;
    localparam logic [15:0] VEC_STRIDE_DEFAULT = 16'h0004;

    // Channel index width; a single-channel build still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - highest-set-bit priority encoder (index plus valid)
module int_prio_enc
    import int_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan upward so the highest set bit is the one left in idx_o.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - prioritised vectored interrupt controller; INT_CTRL_NEST_EN enables nested preemption
module int_ctrl
    import int_pkg::*;
#(
    parameter int               NCH        = 4,
    parameter int               ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(VEC_BASE_DEFAULT),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(VEC_STRIDE_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NCH-1:0]    IRQ,
    input  logic [NCH-1:0]    MASK,
    input  logic              GIE,
    input  logic              ACK,
    input  logic              RTI,
    output logic              REQ,
    output logic [ADDR_W-1:0] ADDRInt,
    output logic [NCH-1:0]    INSVC
);

    localparam int IDX_W = idx_width(NCH);

    int_state_e        state_q, state_d;
    logic [NCH-1:0]    irq_q;
    logic [NCH-1:0]    pend_q, pend_d;
    logic [NCH-1:0]    insvc_q, insvc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [NCH-1:0]    eligible;
    logic [IDX_W-1:0]  cand_idx;
    logic              cand_valid;
    logic [IDX_W-1:0]  insvc_idx;
    logic              insvc_valid;
    logic              offerable;

    assign eligible = pend_q & MASK & {NCH{GIE}};

    int_prio_enc #(.N(NCH), .IDX_W(IDX_W)) u_cand_enc (
        .vec_i   (eligible),
        .idx_o   (cand_idx),
        .valid_o (cand_valid)
    );

    int_prio_enc #(.N(NCH), .IDX_W(IDX_W)) u_insvc_enc (
        .vec_i   (insvc_q),
        .idx_o   (insvc_idx),
        .valid_o (insvc_valid)
    );

`ifdef INT_CTRL_NEST_EN
    // A candidate may preempt only a strictly lower-priority service level.
    assign offerable = cand_valid && (!insvc_valid || (cand_idx > insvc_idx));
`else
    // Without nesting a new offer waits until nothing is in service.
    assign offerable = cand_valid && !insvc_valid;
`endif

    // Next-state: offer/accept/withdraw sequencing plus pend and in-service bookkeeping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        insvc_d = insvc_q;

        // RTI retires the current service level before any ACK in the same cycle lands.
        if (RTI && insvc_valid) begin
            insvc_d[insvc_idx] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (offerable) begin
                    state_d = OFFER;
                    idx_d   = cand_idx;
                    addr_d  = VEC_BASE + ADDR_W'(cand_idx) * VEC_STRIDE;
                end
            end
            OFFER: begin
                // The offer is frozen until accepted; an accept wins over a same-cycle withdraw.
                if (ACK) begin
                    pend_d[idx_q]  = 1'b0;
                    insvc_d[idx_q] = 1'b1;
                    state_d        = IDLE;
                end else if (!(MASK[idx_q] && GIE)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // New edges are merged last so an edge coinciding with ACK is kept as a fresh event.
        pend_d = pend_d | (IRQ & ~irq_q);
    end

    // State register with synchronous reset overriding every other event.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            irq_q   <= '0;
            pend_q  <= '0;
            insvc_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= IRQ;
            pend_q  <= pend_d;
            insvc_q <= insvc_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
        end
    end

    assign REQ     = (state_q == OFFER);
    assign ADDRInt = addr_q;
    assign INSVC   = insvc_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl (directed table, corner sequences, random vs model)
module tb_int_ctrl;

`ifdef INT_CTRL_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  IRQ;
    logic [3:0]  MASK;
    logic        GIE;
    logic        ACK;
    logic        RTI;
    logic        REQ;
    logic [15:0] ADDRInt;
    logic [3:0]  INSVC;

    always #5 CLK = ~CLK;

    int_ctrl #(
        .NCH        (4),
        .ADDR_W     (16),
        .VEC_BASE   (16'h0100),
        .VEC_STRIDE (16'h0004)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .IRQ     (IRQ),
        .MASK    (MASK),
        .GIE     (GIE),
        .ACK     (ACK),
        .RTI     (RTI),
        .REQ     (REQ),
        .ADDRInt (ADDRInt),
        .INSVC   (INSVC)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3:0]  m_prev  = '0;
    logic [3:0]  m_pend  = '0;
    logic [3:0]  m_insvc = '0;
    logic        m_off   = 1'b0;
    int          m_idx   = 0;
    logic [15:0] m_addr  = '0;

    typedef struct {
        logic [3:0]  irq;
        logic        ack;
        logic        rti;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic [3:0]  exp_insvc;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int highest(input logic [3:0] v);
        int h = -1;
        for (int i = 0; i < 4; i++) if (v[i]) h = i;
        return h;
    endfunction

    // Applies the behavioural rules to the inputs present at this clock edge.
    task automatic model_edge();
        logic [3:0] rise, np, ni;
        int cand, top;
        if (RESET) begin
            m_prev = '0; m_pend = '0; m_insvc = '0; m_off = 1'b0; m_addr = '0;
        end else begin
            rise = IRQ & ~m_prev;
            cand = highest(m_pend & MASK & {4{GIE}});
            top  = highest(m_insvc);
            np   = m_pend;
            ni   = m_insvc;
            if (RTI && top >= 0) ni[top] = 1'b0;
            if (m_off) begin
                if (ACK) begin
                    np[m_idx] = 1'b0;
                    ni[m_idx] = 1'b1;
                    m_off = 1'b0;
                end else if (!(MASK[m_idx] && GIE)) begin
                    m_off = 1'b0;
                end
            end else if (cand >= 0 && (top < 0 || (NEST && cand > top))) begin
                m_off  = 1'b1;
                m_idx  = cand;
                m_addr = 16'h0100 + 16'(cand) * 16'h0004;
            end
            m_pend  = np | rise;
            m_insvc = ni;
            m_prev  = IRQ;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; IRQ = '0; ACK = 1'b0; RTI = 1'b0; MASK = 4'hF; GIE = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    task automatic pulse_ack();
        ACK = 1'b1; step(); ACK = 1'b0;
    endtask

    task automatic pulse_rti();
        RTI = 1'b1; step(); RTI = 1'b0;
    endtask

    initial begin
        bit seen;

        tbl[0] = '{4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0};
        tbl[1] = '{4'h2, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0};
        tbl[2] = '{4'h2, 1'b0, 1'b0, 1'b1, 16'h0104, 4'h0};
        tbl[3] = '{4'h2, 1'b0, 1'b0, 1'b1, 16'h0104, 4'h0};
        tbl[4] = '{4'h2, 1'b1, 1'b0, 1'b0, 16'h0104, 4'h2};
        tbl[5] = '{4'h0, 1'b0, 1'b0, 1'b0, 16'h0104, 4'h2};
        tbl[6] = '{4'h0, 1'b0, 1'b1, 1'b0, 16'h0104, 4'h0};
        tbl[7] = '{4'h0, 1'b0, 1'b0, 1'b0, 16'h0104, 4'h0};

        // Reset state and ACK ignored in IDLE
        do_reset();
        step();
        chk("reset_req", REQ, 0);
        chk("reset_addr", ADDRInt, 16'h0000);
        chk("reset_insvc", INSVC, 4'h0);
        pulse_ack();
        chk("ack_idle_insvc", INSVC, 4'h0);
        chk("ack_idle_req", REQ, 0);

        // Single channel offer, latency, accept and return
        do_reset();
        for (int k = 0; k < 8; k++) begin
            IRQ = tbl[k].irq; ACK = tbl[k].ack; RTI = tbl[k].rti;
            step();
            chk($sformatf("tbl%0d_req", k), REQ, tbl[k].exp_req);
            chk($sformatf("tbl%0d_addr", k), ADDRInt, tbl[k].exp_addr);
            chk($sformatf("tbl%0d_insvc", k), INSVC, tbl[k].exp_insvc);
        end
        ACK = 1'b0; RTI = 1'b0;

        // Simultaneous rises: highest first, lower channel after RTI
        do_reset();
        IRQ = 4'b1001; step(); step();
        chk("prio_req", REQ, 1);
        chk("prio_addr", ADDRInt, 16'h010C);
        pulse_ack();
        chk("prio_ack_req", REQ, 0);
        chk("prio_ack_insvc", INSVC, 4'b1000);
        step(); step();
        chk("prio_low_blocked", REQ, 0);
        pulse_rti();
        chk("prio_rti_insvc", INSVC, 4'b0000);
        step();
        chk("prio_ch0_req", REQ, 1);
        chk("prio_ch0_addr", ADDRInt, 16'h0100);
        pulse_ack();
        chk("prio_ch0_insvc", INSVC, 4'b0001);

        // Masked event is retained, then offered once unmasked
        do_reset();
        MASK = 4'b1011; IRQ = 4'b0100;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (REQ) seen = 1'b1;
        end
        chk("masked_no_req", seen, 0);
        MASK = 4'hF; step();
        chk("unmask_req", REQ, 1);
        chk("unmask_addr", ADDRInt, 16'h0108);

        // Withdraw on GIE drop, re-offer, hold despite higher pending, preempt when nesting
        do_reset();
        IRQ = 4'b0100; step(); step();
        chk("wd_req", REQ, 1);
        GIE = 1'b0; step();
        chk("wd_withdrawn", REQ, 0);
        step();
        chk("wd_stays_low", REQ, 0);
        GIE = 1'b1; step();
        chk("wd_reoffer_req", REQ, 1);
        chk("wd_reoffer_addr", ADDRInt, 16'h0108);
        IRQ = 4'b1100; step(); step();
        chk("hold_req", REQ, 1);
        chk("hold_addr", ADDRInt, 16'h0108);
        pulse_ack();
        chk("hold_ack_insvc", INSVC, 4'b0100);
        step();
        chk("preempt_req", REQ, NEST);

        // Rise coinciding with ACK of the same channel is a new event
        do_reset();
        IRQ = 4'b0010; step(); IRQ = 4'b0000; step();
        chk("reack_req", REQ, 1);
        chk("reack_addr", ADDRInt, 16'h0104);
        IRQ = 4'b0010; pulse_ack();
        chk("reack_insvc", INSVC, 4'b0010);
        step();
        chk("reack_blocked", REQ, 0);
        pulse_rti();
        chk("reack_rti_insvc", INSVC, 4'b0000);
        step();
        chk("reack_again_req", REQ, 1);
        chk("reack_again_addr", ADDRInt, 16'h0104);

        // Higher channel while channel 1 in service
        do_reset();
        IRQ = 4'b0010; step(); step();
        pulse_ack();
        chk("nest_base_insvc", INSVC, 4'b0010);
        IRQ = 4'b0000; step();
        IRQ = 4'b1000; step(); step();
`ifdef INT_CTRL_NEST_EN
        chk("nest_req", REQ, 1);
        chk("nest_addr", ADDRInt, 16'h010C);
        pulse_ack();
        chk("nest_insvc", INSVC, 4'b1010);
`else
        chk("nonest_req", REQ, 0);
        step();
        chk("nonest_req2", REQ, 0);
        pulse_rti();
        chk("nonest_rti_insvc", INSVC, 4'b0000);
        step();
        chk("nonest_after_rti_req", REQ, 1);
        chk("nonest_after_rti_addr", ADDRInt, 16'h010C);
        pulse_ack();
        chk("nonest_insvc", INSVC, 4'b1000);
`endif

        // RTI and ACK on the same edge
        do_reset();
`ifdef INT_CTRL_NEST_EN
        IRQ = 4'b0001; step(); step();
        pulse_ack();
        chk("rtiack_base", INSVC, 4'b0001);
        IRQ = 4'b0101; step(); step();
        chk("rtiack_req", REQ, 1);
        chk("rtiack_addr", ADDRInt, 16'h0108);
`else
        IRQ = 4'b0100; step(); step();
        chk("rtiack_req", REQ, 1);
`endif
        ACK = 1'b1; RTI = 1'b1; step(); ACK = 1'b0; RTI = 1'b0;
        chk("rtiack_insvc", INSVC, 4'b0100);

        // Reset in the middle of activity clears everything
        do_reset();
        IRQ = 4'b0100; step(); step();
        pulse_ack();
        IRQ = 4'b0000; step();
        IRQ = 4'b1000; step(); step();
        IRQ = 4'b0000; RESET = 1'b1; step(); RESET = 1'b0;
        chk("rst_req", REQ, 0);
        chk("rst_addr", ADDRInt, 16'h0000);
        chk("rst_insvc", INSVC, 4'b0000);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (REQ) seen = 1'b1;
        end
        chk("rst_pend_cleared", seen, 0);

        // Randomised traffic against the reference model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            IRQ   = IRQ ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            if ($urandom % 10 == 0) MASK = 4'($urandom);
            else if ($urandom % 4 == 0) MASK = 4'hF;
            GIE   = ($urandom % 15) != 0;
            ACK   = m_off ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
            RTI   = ($urandom % 8) == 0;
            RESET = ($urandom % 200) == 0;
            step();
            chk("rnd_req", REQ, m_off);
            chk("rnd_addr", ADDRInt, m_addr);
            chk("rnd_insvc", INSVC, m_insvc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
